// File: rtl/m_gate_sequencer_pkg.sv
// ============================================================================
// Module : m_gate_sequencer_pkg
// Brief  : State encoding, reference truth tables and timer sizing helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package m_gate_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Bit i is the expected gate output for input vector i.
  localparam logic [3:0] c_truth_or2  = 4'b1110;
  localparam logic [3:0] c_truth_and2 = 4'b1000;
  localparam logic [3:0] c_truth_xor2 = 4'b0110;
  localparam logic [1:0] c_truth_buf1 = 2'b10;

  function automatic int timer_width(input int hold);
    return (hold > 1) ? $clog2(hold) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/m_hold_timer.sv
// ============================================================================
// Module : m_hold_timer
// Brief  : Loadable down-counter that flags zero; load value is HOLD-1.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module m_hold_timer
  import m_gate_sequencer_pkg::*;
#(
  parameter int HOLD = 100
) (
  input  logic w_clk,
  input  logic w_rst,
  input  logic w_load,
  input  logic w_dec,
  output logic w_zero
);

  localparam int c_w = timer_width(HOLD);

  logic [c_w-1:0] r_cnt;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= c_w'(HOLD - 1);
    end else if (w_dec && !w_zero) begin
      r_cnt <= r_cnt - c_w'(1);
    end
  end

  assign w_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/m_gate_sequencer.sv
// ============================================================================
// Module : m_gate_sequencer
// Brief  : Walks all input vectors of a gate under test and checks its output.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module m_gate_sequencer
  import m_gate_sequencer_pkg::*;
#(
  parameter int                  N_IN  = 2,
  parameter int                  HOLD  = 100,
  parameter logic [2**N_IN-1:0]  TRUTH = 4'b1110
) (
  input  logic            w_clk,
  input  logic            w_rst,
  input  logic            w_start,
  input  logic            w_gate_out,
  output logic [N_IN-1:0] r_vec,
  output logic            w_busy,
  output logic            w_chk_valid,
  output logic            w_chk_pass,
  output logic            w_done,
  output logic [N_IN:0]   r_err_cnt,
  output logic            r_err
);

  localparam logic [N_IN-1:0] c_last = {N_IN{1'b1}};

  state_t r_state;
  logic   w_accept;
  logic   w_load;
  logic   w_dec;
  logic   w_zero;
  logic   w_match;

  assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && w_start;
  assign w_load   = w_accept || ((r_state == S_SAMPLE) && (r_vec != c_last));
  assign w_dec    = (r_state == S_SETTLE);
  assign w_match  = (w_gate_out == TRUTH[r_vec]);

  m_hold_timer #(
    .HOLD (HOLD)
  ) u_hold_timer (
    .w_clk  (w_clk),
    .w_rst  (w_rst),
    .w_load (w_load),
    .w_dec  (w_dec),
    .w_zero (w_zero)
  );

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_state   <= S_IDLE;
      r_vec     <= '0;
      r_err_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            r_state   <= S_SETTLE;
            r_vec     <= '0;
            r_err_cnt <= '0;
            r_err     <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (w_zero) begin
            r_state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          if (!w_match) begin
            r_err_cnt <= r_err_cnt + (N_IN+1)'(1);
            r_err     <= 1'b1;
          end
          // The last vector is kept on r_vec so the final result stays readable.
          if (r_vec == c_last) begin
            r_state <= S_DONE;
          end else begin
            r_state <= S_SETTLE;
            r_vec   <= r_vec + N_IN'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_busy      = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
  assign w_chk_valid = (r_state == S_SAMPLE);
  assign w_chk_pass  = (r_state == S_SAMPLE) && w_match;
  assign w_done      = (r_state == S_DONE);

endmodule

`default_nettype wire
